// File: rtl/sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
//
// Serial-in, parallel-out shift register with word framing. While `load` is
// high, each rising clock edge shifts `serial_in` into bit 0 and moves the
// older bits toward the MSB. A bit counter tracks how many bits have arrived
// in the current word. When the WIDTH-th bit enters, the counter wraps to 0
// and `word_valid` pulses for one cycle, so downstream logic can sample the
// assembled word from `parallel_out`.
//
// Shifting does not stop at word boundaries. The register behaves as a sliding
// window, and `word_valid` marks every WIDTH-th accepted bit.
//
// Every output comes straight from a flop. There is no combinational path
// from any input to any output.
//
// Optional build feature (macro SIPO_PARITY_EN):
//   parity_out  - XOR of all bits of parallel_out, updated on the same edge
//                 as parallel_out.
//   word_parity - parity of the most recently completed word. It is captured
//                 on the edge that raises word_valid and held otherwise.
//   If the macro is not defined, neither port exists and no parity logic is
//   built.
//
// Parameters:
//   WIDTH  - register width in bits (2 or more)
//   CNT_W  - width of bit_count; derived from WIDTH, do not override
//
// Ports:
//   clk           in   system clock, rising edge active
//   reset         in   asynchronous reset, active low
//   serial_in     in   serial data bit, sampled when load = 1
//   load          in   shift enable (1 = shift, 0 = hold)
//   parallel_out  out  register contents; newest bit at [0]
//   bit_count     out  bits received in the current word (0..WIDTH-1)
//   word_valid    out  one-cycle pulse after the WIDTH-th bit of a word
//   parity_out    out  (SIPO_PARITY_EN) XOR of parallel_out
//   word_parity   out  (SIPO_PARITY_EN) parity of the last completed word
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             load,
  output logic [WIDTH-1:0] parallel_out,
  output logic [CNT_W-1:0] bit_count,
  output logic             word_valid
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_out,
  output logic             word_parity
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Register contents after one shift: drop the MSB, append the new bit.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             bit_in);
    return {cur[WIDTH-2:0], bit_in};
  endfunction

  // Bit counter advance: wraps to zero when the current word completes.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur);
    if (cur == LAST_CNT) begin
      return '0;
    end
    return cur + CNT_W'(1);
  endfunction

`ifdef SIPO_PARITY_EN
  function automatic logic reduce_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  logic [WIDTH-1:0] shift_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             vld_p0;
  logic [WIDTH-1:0] shift_nxt;
  logic             word_done;

  // The next register value and the word-complete condition are computed
  // here. They feed the flops below and never reach an output directly.
  assign shift_nxt = shift_in(shift_p0, serial_in);
  assign word_done = load && (cnt_p0 == LAST_CNT);

  // ---- stage p0: shift register, bit counter, word strobe ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_p0 <= '0;
      cnt_p0   <= '0;
      vld_p0   <= 1'b0;
    end else begin
      // word_valid is a single-cycle strobe, so it clears whenever load is
      // low as well as on every non-completing shift.
      vld_p0 <= word_done;
      if (load) begin
        shift_p0 <= shift_nxt;
        cnt_p0   <= next_count(cnt_p0);
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic par_p0;
  logic word_par_p0;

  // ---- stage p0: parity, tracking the shift register edge for edge ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_p0      <= 1'b0;
      word_par_p0 <= 1'b0;
    end else if (load) begin
      par_p0 <= reduce_parity(shift_nxt);
      // The completed word is the value entering the register on this edge.
      if (word_done) begin
        word_par_p0 <= reduce_parity(shift_nxt);
      end
    end
  end

  assign parity_out  = par_p0;
  assign word_parity = word_par_p0;
`endif

  assign parallel_out = shift_p0;
  assign bit_count    = cnt_p0;
  assign word_valid   = vld_p0;

endmodule

// File: tb/tb_sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_sipo_shift_reg
//
// Directed bench for sipo_shift_reg (WIDTH = 8).
// - Inputs change on the falling clock edge.
// - Outputs are sampled 1 ns after each rising edge.
// - Expected values are written out by hand from the serial bit sequences.
// - Parity checks are built only when SIPO_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_sipo_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset;
  logic             serial_in;
  logic             load;
  logic [WIDTH-1:0] parallel_out;
  logic [CNT_W-1:0] bit_count;
  logic             word_valid;
`ifdef SIPO_PARITY_EN
  logic             parity_out;
  logic             word_parity;
`endif

  int vectors;
  int miscompares;

  sipo_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .load         (load),
    .parallel_out (parallel_out),
    .bit_count    (bit_count),
    .word_valid   (word_valid)
`ifdef SIPO_PARITY_EN
    ,
    .parity_out   (parity_out),
    .word_parity  (word_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Assert reset between edges and confirm the asynchronous clear before any
  // clock edge can occur, then release it while the clock keeps running.
  task automatic do_reset(input string tag);
    @(negedge clk);
    load      = 1'b0;
    serial_in = 1'b0;
    #1 reset  = 1'b0;
    #1;
    check({tag, "_async_pout"}, 32'(parallel_out), 32'h00);
    check({tag, "_async_cnt"},  32'(bit_count),    32'd0);
    check({tag, "_async_vld"},  32'(word_valid),   32'd0);
    #4 reset = 1'b1;
    #1;
    check({tag, "_rel_pout"}, 32'(parallel_out), 32'h00);
    check({tag, "_rel_cnt"},  32'(bit_count),    32'd0);
  endtask

  // Apply one bit with load high and sample right after the rising edge.
  task automatic shift_bit(input logic b);
    @(negedge clk);
    load      = 1'b1;
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  // A word: bits w[7] first down to w[0] last, so the result equals w.
  task automatic shift_word(input string tag, input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      shift_bit(w[7-i]);
      check({tag, "_cnt"}, 32'(bit_count), 32'((i + 1) % 8));
      check({tag, "_vld"}, 32'(word_valid), (i == 7) ? 32'd1 : 32'd0);
    end
    check({tag, "_pout"}, 32'(parallel_out), 32'(w));
  endtask

  logic [15:0] stream;
  int          pulses;
  int          pulse_edge [2];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    load        = 1'b0;
    serial_in   = 1'b0;

    // Reset
    do_reset("reset");

    // Word 1: 1,0,1,1,0,1,0,1 -> 8'b10110101, popcount 5
    shift_word("word1", 8'b10110101);
`ifdef SIPO_PARITY_EN
    check("word1_wpar", 32'(word_parity), 32'd1);
    check("word1_par",  32'(parity_out),  32'd1);
`endif
    // Strobe drops one cycle later when load goes low
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    #1;
    check("word1_vld_drop", 32'(word_valid), 32'd0);

    // Mid-stream reset: start from a clean register, shift 1,1,1
    do_reset("pre_mid");
    for (int i = 0; i < 3; i++) begin
      shift_bit(1'b1);
      check("mid_vld", 32'(word_valid), 32'd0);
    end
    check("mid_pout", 32'(parallel_out), 32'h07);
    check("mid_cnt",  32'(bit_count),    32'd3);
    do_reset("mid_rst");

    // Word 2 after reset: 0,1,1,0,0,1,1,0 -> 8'b01100110, popcount 4
    shift_word("word2", 8'b01100110);
`ifdef SIPO_PARITY_EN
    check("word2_par",  32'(parity_out),  32'd0);
    check("word2_wpar", 32'(word_parity), 32'd0);
`endif

    // Hold: 1,0,0,1 from clean state, then load low with serial_in toggling
    do_reset("pre_hold");
    shift_bit(1'b1);
    shift_bit(1'b0);
    shift_bit(1'b0);
    shift_bit(1'b1);
    check("hold_pre_pout", 32'(parallel_out), 32'h09);
    check("hold_pre_cnt",  32'(bit_count),    32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      load      = 1'b0;
      serial_in = ~serial_in;
      @(posedge clk);
      #1;
      check("hold_pout", 32'(parallel_out), 32'h09);
      check("hold_cnt",  32'(bit_count),    32'd4);
      check("hold_vld",  32'(word_valid),   32'd0);
    end

    // Continuous stream of 16 bits, MSB of stream first:
    // 1,1,0,0,1,0,1,0, 0,1,1,1,0,0,1,0
    do_reset("pre_stream");
    stream        = 16'b1100101001110010;
    pulses        = 0;
    pulse_edge[0] = 0;
    pulse_edge[1] = 0;
    for (int k = 1; k <= 16; k++) begin
      shift_bit(stream[16-k]);
      check("stream_cnt", 32'(bit_count), 32'(k % 8));
      if (word_valid === 1'b1) begin
        if (pulses < 2) pulse_edge[pulses] = k;
        pulses++;
      end
      if (k == 8) check("stream_pout8", 32'(parallel_out), 32'hCA);
    end
    check("stream_pout16", 32'(parallel_out), 32'h72);
    check("stream_pulses", 32'(pulses),        32'd2);
    check("stream_edge1",  32'(pulse_edge[0]), 32'd8);
    check("stream_edge2",  32'(pulse_edge[1]), 32'd16);

    @(negedge clk);
    load = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
